reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 16, data bits per entry.
- DEPTH, 16, entry count; power of two, at least 2.
- ADDR_W, clog2(DEPTH), address bits; derived, never overridden.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high; sampled on rising edge of clk.
- write_enable, in, 1, commits data_in to write_addr at the edge.
- write_addr, in, ADDR_W, destination entry.
- data_in, in, WIDTH, write data.
- read_addr_a, in, ADDR_W, port A source entry.
- read_addr_b, in, ADDR_W, port B source entry.
- data_out_a, out, WIDTH, port A read data.
- data_out_b, out, WIDTH, port B read data.

Function
REQ-003 Reads SHALL be combinational: data_out_x equals the entry at read_addr_x in the same cycle, zero latency.
REQ-004 Writes SHALL take effect at the rising edge when write_enable=1 and reset=0; the stored value is visible on reads from the following cycle (BYPASS=0).
REQ-005 With write_enable=0, no entry SHALL change, whatever data_in and write_addr do.
REQ-006 With BYPASS=1, write_enable=1 and read_addr_x == write_addr (and not zero-reg-masked), data_out_x SHALL equal data_in combinationally in the same cycle.
REQ-007 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be discarded, including via bypass.
REQ-008 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data.
REQ-009 Exactly one entry SHALL be written per enabled cycle; no other entry changes.
REQ-010 Unknown/X on write_addr with write_enable=0 SHALL NOT corrupt any entry.

Reset
REQ-011 reset=1 at a rising edge SHALL clear every entry to 0; data_out_a/b SHALL read 0 from the next cycle for all addresses.
REQ-012 reset SHALL take priority over write_enable in the same edge; the write SHALL be lost.
REQ-013 Bypass SHALL be suppressed while reset=1; outputs reflect stored (pre-reset) contents until the edge.
REQ-014 A write in the first cycle after reset deasserts SHALL be honoured normally.

Structure
REQ-015 Shared package rf_pkg SHALL hold default WIDTH/DEPTH constants and the clog2 helper; reg_file SHALL import it.
REQ-016 Storage SHALL be DEPTH instances of sub-module rf_cell (WIDTH-bit, synchronous-reset, write-enabled register); entry 0 SHALL be omitted when ZERO_REG=1.
REQ-017 Write decode and read muxes/bypass SHALL live in reg_file; no latches, no multi-clock logic.

Verification
REQ-018 Reset: write 16'hAAAA to all 16 entries, assert reset one cycle -> all reads return 16'h0000 next cycle.
REQ-019 Write-enable gating: write_enable=0, data_in=16'h0001, write_addr=3 for 2 cycles -> read_addr_a=3 returns 0; then write_enable=1 one cycle -> returns 16'h0001; set data_in=16'h000F with write_enable=0 -> still 16'h0001.
REQ-020 Bypass: BYPASS=1, write_enable=1, write_addr=5, data_in=16'h1234, read_addr_a=5 -> data_out_a=16'h1234 same cycle; BYPASS=0 instance -> old value (0) same cycle, 16'h1234 next cycle.
REQ-021 Zero register: ZERO_REG=1, write 16'hFFFF to address 0 with read_addr_b=0 -> data_out_b=0 in same and next cycle; ZERO_REG=0 -> 16'hFFFF next cycle.
REQ-022 Reset vs write collision: reset=1 and write_enable=1, write_addr=7, data_in=16'hBEEF same edge -> entry 7 reads 0 after edge.
REQ-023 Dual-port independence: entries 2=16'h0022, 9=16'h0099; read_addr_a=2, read_addr_b=9 -> 16'h0022/16'h0099; both =9 -> both 16'h0099.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file and its storage cell.
package rf_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 16;

  // Ceiling log2 for deriving address widths from entry counts.
  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_cell.sv
// One storage entry: WIDTH-bit register with synchronous clear and write enable.
module rf_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: hold unless this entry is selected for writing.
  always_comb begin
    data_d = data_q;
    if (we_i) data_d = d_i;
  end

  // Clear wins over a write arriving at the same edge.
  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with optional hard-wired zero entry
// and optional same-cycle write-to-read forwarding.
module reg_file
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = rf_clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic             fwd_ok;

  // Storage: entry 0 is a constant zero when the zero register is enabled,
  // so it has no cell and no write decode.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign entry_q[i] = '0;
    end else begin : g_cell
      rf_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .reset (reset),
        .we_i  (write_enable && (write_addr == ADDR_W'(i))),
        .d_i   (data_in),
        .q_o   (entry_q[i])
      );
    end
  end

  // Forwarding is allowed only for a write that will actually land: not
  // during reset and not to the hard-wired zero entry.
  always_comb begin
    fwd_ok = (BYPASS != 0) && write_enable && !reset;
    if ((ZERO_REG != 0) && (write_addr == '0)) fwd_ok = 1'b0;
  end

  // Port A read mux with forwarding.
  always_comb begin
    data_out_a = entry_q[read_addr_a];
    if (fwd_ok && (read_addr_a == write_addr)) data_out_a = data_in;
  end

  // Port B read mux with forwarding.
  always_comb begin
    data_out_b = entry_q[read_addr_b];
    if (fwd_ok && (read_addr_b == write_addr)) data_out_b = data_in;
  end

endmodule
